// File: rtl/blk_4e5178_if.sv
// Operand/result handshake bundle for the sequential arithmetic left shifter.
// master drives operands and consumes results; slave is the shifter itself.
interface blk_4e5178_if #(
  parameter int N  = 8,
  parameter int SW = 3
);
  logic          arg_vld;
  logic          arg_rdy;
  logic [N-1:0]  a;
  logic [SW-1:0] s;
  logic          res_vld;
  logic          res_rdy;
  logic [N-1:0]  res;
  logic          ovf;

  modport master (
    output arg_vld, a, s, res_rdy,
    input  arg_rdy, res_vld, res, ovf
  );

  modport slave (
    input  arg_vld, a, s, res_rdy,
    output arg_rdy, res_vld, res, ovf
  );
endinterface

// File: rtl/blk_4e5178.sv
// Sequential signed multiply by 2**s: one bit of arithmetic left shift per clock, sticky overflow.
// Define SATURATE_EN to clamp overflowed results to the signed limits instead of wrapping.
module blk_4e5178 #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic         clk,
  input  logic         rst,
  blk_4e5178_if.slave  bus
);

`ifdef SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  acc_reg, acc_next;
  logic [N-1:0]  res_reg, res_next;
  logic [SW-1:0] cnt_reg, cnt_next;
  logic          sign_reg, sign_next;
  logic          ovf_reg, ovf_next;

  // A step overflows when the bit about to become the sign differs from the current sign.
  logic [N-1:0]  shifted;
  logic          ovf_step;
  logic [N-1:0]  final_res;

  assign shifted   = {acc_reg[N-2:0], 1'b0};
  assign ovf_step  = ovf_reg | (acc_reg[N-1] ^ acc_reg[N-2]);
  assign final_res = (SAT_EN && ovf_step) ? (sign_reg ? SAT_NEG : SAT_POS) : shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
      sign_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      res_reg   <= res_next;
      cnt_reg   <= cnt_next;
      sign_reg  <= sign_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    res_next   = res_reg;
    cnt_next   = cnt_reg;
    sign_next  = sign_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (bus.arg_vld) begin
          acc_next  = bus.a;
          cnt_next  = bus.s;
          sign_next = bus.a[N-1];
          ovf_next  = 1'b0;
          if (bus.s == '0) begin
            res_next   = bus.a;
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_next = shifted;
        ovf_next = ovf_step;
        cnt_next = cnt_reg - SW'(1);
        if (cnt_reg == SW'(1)) begin
          res_next   = final_res;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.res_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.arg_rdy = (state_reg == IDLE);
  assign bus.res_vld = (state_reg == DONE);
  assign bus.res     = res_reg;
  assign bus.ovf     = ovf_reg;

endmodule
